// File: rtl/credit_fifo_if.sv
// Handshake, flush and status signals of credit_fifo grouped into one bundle.
interface credit_fifo_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             in_genfifo_req_i;
    logic [WIDTH-1:0] in_genfifo_rdata_bi;
    logic             in_genfifo_ack_o;
    logic             out_genfifo_req_o;
    logic [WIDTH-1:0] out_genfifo_wdata_bo;
    logic             out_genfifo_ack_i;
    logic             flush_i;
    logic [CW-1:0]    credits_o;
    logic [CW-1:0]    max_count_o;
    logic [31:0]      stall_cnt_o;

    // Environment side: drives upstream data, downstream ack and flush.
    modport master (
        output in_genfifo_req_i, in_genfifo_rdata_bi, out_genfifo_ack_i, flush_i,
        input  in_genfifo_ack_o, out_genfifo_req_o, out_genfifo_wdata_bo,
               credits_o, max_count_o, stall_cnt_o
    );

    // FIFO side.
    modport slave (
        input  in_genfifo_req_i, in_genfifo_rdata_bi, out_genfifo_ack_i, flush_i,
        output in_genfifo_ack_o, out_genfifo_req_o, out_genfifo_wdata_bo,
               credits_o, max_count_o, stall_cnt_o
    );
endinterface

// File: rtl/credit_fifo.sv
// Credit-based first-word-fall-through FIFO with high-water mark and stall counter.
module credit_fifo #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 4,
    parameter bit          HWM_EN = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    credit_fifo_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    max_q, max_d;
    logic [31:0]      stall_q, stall_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic          in_ack_c;
    logic          out_req_c;
    logic          push_c;
    logic          pop_c;
    logic [CW-1:0] credits_c;

    // Handshake decode; a full FIFO refuses a push even when a pop frees a slot this cycle.
    always_comb begin
        credits_c = CW'(DEPTH) - count_q;
        in_ack_c  = bus.in_genfifo_req_i && (credits_c != '0) && !bus.flush_i && !rst_i;
        out_req_c = (count_q != '0) && !bus.flush_i && !rst_i;
        push_c    = in_ack_c;
        pop_c     = out_req_c && bus.out_genfifo_ack_i;
    end

    // Next-state: pointers, occupancy, peak tracking and stall count; flush overrides all but stall.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        max_d   = max_q;
        stall_d = stall_q;
        mem_d   = mem_q;

        if (push_c) begin
            mem_d[wptr_q] = bus.in_genfifo_rdata_bi;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (HWM_EN && (count_d > max_q)) begin
            max_d = count_d;
        end
        if (out_req_c && !bus.out_genfifo_ack_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if (bus.flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            max_d   = '0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            max_q   <= '0;
            stall_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            max_q   <= max_d;
            stall_q <= stall_d;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign bus.in_genfifo_ack_o     = in_ack_c;
    assign bus.out_genfifo_req_o    = out_req_c;
    assign bus.out_genfifo_wdata_bo = mem_q[rptr_q];
    assign bus.credits_o            = credits_c;
    assign bus.max_count_o          = HWM_EN ? max_q : '0;
    assign bus.stall_cnt_o          = stall_q;

endmodule

// File: tb/tb_credit_fifo.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_credit_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    credit_fifo_if #(.WIDTH(16), .DEPTH(4))  ifa ();
    credit_fifo_if #(.WIDTH(32), .DEPTH(16)) ifb ();

    credit_fifo #(.WIDTH(16), .DEPTH(4), .HWM_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa)
    );
    credit_fifo #(.WIDTH(32), .DEPTH(16), .HWM_EN(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit soak    = 1'b0;
    int sink_exp = 1;
    int n_sunk   = 0;

    // Reference model state (state after the most recent clock edge).
    logic [31:0] mqa[$];
    logic [31:0] mqb[$];
    logic [31:0] st_a = 0, st_b = 0;
    int          hwm_a = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_dut(input string tg, input int dep, input int sz,
                           input logic [31:0] head, input logic [31:0] stall, input int hwm,
                           input logic req, input logic flush,
                           input logic a_iack, input logic a_oreq, input logic [31:0] a_wd,
                           input logic [31:0] a_cr, input logic [31:0] a_max,
                           input logic [31:0] a_st);
        logic e_iack, e_oreq;
        chk({tg, "_credits"}, a_cr, 32'(dep - sz));
        chk({tg, "_max_count"}, a_max, 32'(hwm));
        chk({tg, "_stall_cnt"}, a_st, stall);
        if (!rst) begin
            e_iack = req && !flush && (sz < dep);
            e_oreq = !flush && (sz > 0);
            chk({tg, "_in_ack"}, 32'(a_iack), 32'(e_iack));
            chk({tg, "_out_req"}, 32'(a_oreq), 32'(e_oreq));
            if (e_oreq) chk({tg, "_wdata"}, a_wd, head);
        end
    endtask

    // Per-cycle comparison against the model, then the model takes the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("a", 4, mqa.size(), (mqa.size() > 0) ? mqa[0] : 32'd0, st_a, hwm_a,
                    ifa.in_genfifo_req_i, ifa.flush_i, ifa.in_genfifo_ack_o,
                    ifa.out_genfifo_req_o, 32'(ifa.out_genfifo_wdata_bo),
                    32'(ifa.credits_o), 32'(ifa.max_count_o), ifa.stall_cnt_o);
            cmp_dut("b", 16, mqb.size(), (mqb.size() > 0) ? mqb[0] : 32'd0, st_b, 0,
                    ifb.in_genfifo_req_i, ifb.flush_i, ifb.in_genfifo_ack_o,
                    ifb.out_genfifo_req_o, ifb.out_genfifo_wdata_bo,
                    32'(ifb.credits_o), 32'(ifb.max_count_o), ifb.stall_cnt_o);
        end
        // model A
        if (rst) begin
            mqa.delete(); st_a = 0; hwm_a = 0;
        end else if (ifa.flush_i) begin
            mqa.delete(); hwm_a = 0;
        end else begin
            bit e_or, e_ia;
            e_or = mqa.size() > 0;
            e_ia = ifa.in_genfifo_req_i && (mqa.size() < 4);
            if (e_or && !ifa.out_genfifo_ack_i && st_a != 32'hFFFF_FFFF) st_a++;
            if (e_or && ifa.out_genfifo_ack_i) begin
                if (soak && chk_en) begin
                    chk("soak_order", 32'(ifa.out_genfifo_wdata_bo), 32'(sink_exp));
                    sink_exp = (sink_exp == 400) ? 1 : sink_exp + 1;
                    n_sunk++;
                end
                void'(mqa.pop_front());
            end
            if (e_ia) mqa.push_back(32'(ifa.in_genfifo_rdata_bi));
            if (mqa.size() > hwm_a) hwm_a = mqa.size();
        end
        // model B (no high-water tracking)
        if (rst) begin
            mqb.delete(); st_b = 0;
        end else if (ifb.flush_i) begin
            mqb.delete();
        end else begin
            bit e_or, e_ia;
            e_or = mqb.size() > 0;
            e_ia = ifb.in_genfifo_req_i && (mqb.size() < 16);
            if (e_or && !ifb.out_genfifo_ack_i && st_b != 32'hFFFF_FFFF) st_b++;
            if (e_or && ifb.out_genfifo_ack_i) void'(mqb.pop_front());
            if (e_ia) mqb.push_back(ifb.in_genfifo_rdata_bi);
        end
    end

    // Runaway guard.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int src;
        ifa.in_genfifo_req_i = 1'b0; ifa.in_genfifo_rdata_bi = '0;
        ifa.out_genfifo_ack_i = 1'b0; ifa.flush_i = 1'b0;
        ifb.in_genfifo_req_i = 1'b0; ifb.in_genfifo_rdata_bi = '0;
        ifb.out_genfifo_ack_i = 1'b0; ifb.flush_i = 1'b0;
        rst = 1'b1;
        cyc();
        chk_en = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("rst_credits", 32'(ifa.credits_o), 32'd4);
        chk("rst_in_ack", 32'(ifa.in_genfifo_ack_o), 32'd0);
        chk("rst_out_req", 32'(ifa.out_genfifo_req_o), 32'd0);
        chk("rst_stall", ifa.stall_cnt_o, 32'd0);
        chk("rst_max", 32'(ifa.max_count_o), 32'd0);
        cyc();

        // Fill with no drain.
        for (int i = 0; i < 5; i++) begin
            ifa.in_genfifo_req_i = 1'b1; ifa.in_genfifo_rdata_bi = 16'(i + 1);
            #1;
            chk("fill_ack", 32'(ifa.in_genfifo_ack_o), 32'(i < 4));
            chk("fill_credits", 32'(ifa.credits_o), 32'(4 - i));
            chk("fill_max", 32'(ifa.max_count_o), 32'(i));
            chk("fill_stall", ifa.stall_cnt_o, 32'((i == 0) ? 0 : i - 1));
            cyc();
        end

        // Pop at full: no same-cycle push, credit usable next cycle.
        ifa.in_genfifo_rdata_bi = 16'd5; ifa.out_genfifo_ack_i = 1'b1;
        #1;
        chk("full_pop_ack", 32'(ifa.in_genfifo_ack_o), 32'd0);
        chk("full_pop_credits", 32'(ifa.credits_o), 32'd0);
        chk("full_pop_wdata", 32'(ifa.out_genfifo_wdata_bo), 32'd1);
        cyc();
        ifa.out_genfifo_ack_i = 1'b0;
        #1;
        chk("freed_credits", 32'(ifa.credits_o), 32'd1);
        chk("freed_ack", 32'(ifa.in_genfifo_ack_o), 32'd1);
        chk("freed_wdata", 32'(ifa.out_genfifo_wdata_bo), 32'd2);
        cyc();
        #1;
        chk("refull_credits", 32'(ifa.credits_o), 32'd0);
        ifa.in_genfifo_req_i = 1'b0; ifa.out_genfifo_ack_i = 1'b1;
        #1;
        chk("drain_wdata0", 32'(ifa.out_genfifo_wdata_bo), 32'd2);
        cyc();
        #1;
        chk("drain_wdata1", 32'(ifa.out_genfifo_wdata_bo), 32'd3);
        cyc();

        // Streaming at count=2.
        for (int i = 0; i < 10; i++) begin
            ifa.in_genfifo_req_i = 1'b1; ifa.in_genfifo_rdata_bi = 16'(6 + i);
            ifa.out_genfifo_ack_i = 1'b1;
            #1;
            chk("stream_credits", 32'(ifa.credits_o), 32'd2);
            chk("stream_out_req", 32'(ifa.out_genfifo_req_o), 32'd1);
            chk("stream_wdata", 32'(ifa.out_genfifo_wdata_bo), 32'(4 + i));
            cyc();
        end

        // Flush at count=3 while upstream offers.
        ifa.out_genfifo_ack_i = 1'b0; ifa.in_genfifo_rdata_bi = 16'd16;
        cyc();
        ifa.flush_i = 1'b1; ifa.in_genfifo_rdata_bi = 16'd17;
        #1;
        chk("flush_credits_before", 32'(ifa.credits_o), 32'd1);
        chk("flush_in_ack", 32'(ifa.in_genfifo_ack_o), 32'd0);
        chk("flush_out_req", 32'(ifa.out_genfifo_req_o), 32'd0);
        cyc();
        ifa.flush_i = 1'b0; ifa.in_genfifo_req_i = 1'b0;
        #1;
        chk("post_flush_credits", 32'(ifa.credits_o), 32'd4);
        chk("post_flush_max", 32'(ifa.max_count_o), 32'd0);
        chk("post_flush_out_req", 32'(ifa.out_genfifo_req_o), 32'd0);
        cyc();

        // Reset mid-transfer, with flush also asserted.
        ifa.in_genfifo_req_i = 1'b1; ifa.in_genfifo_rdata_bi = 16'd20;
        repeat (2) cyc();
        rst = 1'b1; ifa.out_genfifo_ack_i = 1'b1; ifa.flush_i = 1'b1;
        cyc();
        rst = 1'b0; ifa.in_genfifo_req_i = 1'b0; ifa.out_genfifo_ack_i = 1'b0;
        ifa.flush_i = 1'b0;
        #1;
        chk("post_rst_credits", 32'(ifa.credits_o), 32'd4);
        chk("post_rst_stall", ifa.stall_cnt_o, 32'd0);
        chk("post_rst_out_req", 32'(ifa.out_genfifo_req_o), 32'd0);
        cyc();

        // Soak with mostly-stalled sink.
        soak = 1'b1; src = 1;
        for (int i = 0; i < 4000; i++) begin
            ifa.in_genfifo_req_i = 1'b1; ifa.in_genfifo_rdata_bi = 16'(src);
            ifa.out_genfifo_ack_i = ($urandom_range(0, 9) == 0);
            #1;
            if (ifa.in_genfifo_ack_o) src = (src == 400) ? 1 : src + 1;
            cyc();
        end
        soak = 1'b0;
        ifa.in_genfifo_req_i = 1'b0; ifa.out_genfifo_ack_i = 1'b0;
        chk("soak_words_out", 32'(n_sunk > 300), 32'd1);
        cyc();

        // Deep instance without high-water tracking.
        for (int i = 0; i < 17; i++) begin
            ifb.in_genfifo_req_i = 1'b1; ifb.in_genfifo_rdata_bi = 32'(i + 1);
            #1;
            chk("b_fill_ack", 32'(ifb.in_genfifo_ack_o), 32'(i < 16));
            chk("b_fill_credits", 32'(ifb.credits_o), 32'(16 - i));
            chk("b_fill_max", 32'(ifb.max_count_o), 32'd0);
            cyc();
        end
        ifb.in_genfifo_req_i = 1'b0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/credit_fifo.md
CREDIT_FIFO -- requirements
Module: credit_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning buffer entries; a power of two, >=2.
REQ-003 The block SHALL have parameter HWM_EN, default 1, meaning high-water-mark tracking is enabled; 0 ties max_count_o to 0.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1, a synchronous, active-high reset.
REQ-006 The block SHALL have port in_genfifo_req_i, input, 1, meaning upstream offers a word.
REQ-007 The block SHALL have port in_genfifo_rdata_bi, input, WIDTH, meaning the upstream word.
REQ-008 The block SHALL have port in_genfifo_ack_o, output, 1, meaning the word is accepted this cycle.
REQ-009 The block SHALL have port out_genfifo_req_o, output, 1, meaning a word is offered downstream.
REQ-010 The block SHALL have port out_genfifo_wdata_bo, output, WIDTH, meaning the downstream word.
REQ-011 The block SHALL have port out_genfifo_ack_i, input, 1, meaning downstream takes the word this cycle.
REQ-012 The block SHALL have port flush_i, input, 1, meaning discard all buffered words.
REQ-013 The block SHALL have port credits_o, output, clog2(DEPTH)+1, meaning free entries (DEPTH - count).
REQ-014 The block SHALL have port max_count_o, output, clog2(DEPTH)+1, meaning peak occupancy since reset or flush.
REQ-015 The block SHALL have port stall_cnt_o, output, 32, meaning cycles where out_genfifo_req_o=1 and out_genfifo_ack_i=0.

Function
REQ-016 The block SHALL hold words in a DEPTH-entry circular buffer with read/write pointers that wrap modulo DEPTH, plus an occupancy counter count in 0..DEPTH.
REQ-017 in_genfifo_ack_o SHALL equal in_genfifo_req_i AND (credits_o>0) AND NOT flush_i; it SHALL NOT depend combinationally on out_genfifo_ack_i.
REQ-018 A push SHALL occur when in_genfifo_req_i and in_genfifo_ack_o are both 1; it writes in_genfifo_rdata_bi at the write pointer and advances it.
REQ-019 out_genfifo_req_o SHALL equal (count>0) AND NOT flush_i; out_genfifo_wdata_bo SHALL present the entry at the read pointer (first-word fall-through).
REQ-020 A pop SHALL occur when out_genfifo_req_o and out_genfifo_ack_i are both 1; it advances the read pointer.
REQ-021 Latency SHALL be one cycle: a word pushed at edge N is offered on out_genfifo_* from edge N onward.
REQ-022 Simultaneous push and pop SHALL leave count unchanged. Both pointers SHALL advance.
REQ-023 At count=DEPTH a simultaneous pop SHALL NOT enable a push in the same cycle; the freed credit is usable next cycle.
REQ-024 Words SHALL leave in acceptance order, with no loss or duplication across pointer wrap-around.
REQ-025 out_genfifo_wdata_bo SHALL hold stable while out_genfifo_req_o=1 and no pop occurs.
REQ-026 flush_i=1 SHALL, at the next edge, zero the pointers, count and max_count_o. It takes priority over push and pop. stall_cnt_o is retained.
REQ-027 With HWM_EN=1, max_count_o SHALL update to count_next whenever count_next exceeds it.
REQ-028 stall_cnt_o SHALL increment by 1 per stall cycle and saturate at 0xFFFFFFFF.
REQ-029 out_genfifo_ack_i while out_genfifo_req_o=0 SHALL be ignored; count never underflows.

Reset
REQ-030 rst_i=1 at an edge SHALL set the pointers, count, max_count_o and stall_cnt_o to 0. The outputs then read in_genfifo_ack_o=0, out_genfifo_req_o=0 and credits_o=DEPTH. Buffer contents are not cleared.
REQ-031 rst_i asserted mid-transfer SHALL discard buffered words; no push or pop takes effect in a reset cycle, and rst_i has priority over flush_i.

Verification
REQ-032 The bench SHALL apply reset, then in_req=1 with data 1,2,3,... and out_ack=0 (DEPTH=4). Required: ack for 4 cycles, then ack=0; credits_o 4->0; max_count_o=4; stall_cnt_o increments every cycle from the first push.
REQ-033 The bench SHALL, at count=2, hold in_req=1 and out_ack=1 for 10 cycles. Required: count stays 2; outputs appear in order with no gaps.
REQ-034 The bench SHALL, at count=4, assert out_ack=1 for one cycle with in_req=1. Required: one pop, no push that cycle, push next cycle; credits_o 0->1->0.
REQ-035 The bench SHALL assert flush_i at count=3 with in_req=1. Required: in_ack=0 that cycle; next cycle count=0, credits_o=4, max_count_o=0, out_req=0.
REQ-036 The bench SHALL run a 4000-cycle soak: input 1..400 wrapping to 1, in_req=1, out_ack random (weights 1:9). Required: sink sequence strictly matches source order; credits_o+count=DEPTH every cycle.
REQ-037 The bench SHALL build with WIDTH=32, DEPTH=16 and HWM_EN=0 and repeat REQ-032 scaled to 16 entries. Required: ack drops after 16 pushes; max_count_o=0.
